// File: rtl/host_mem_ctrl.sv
// Host-accessible register memory: byte-enabled writes, registered reads with valid strobe,
// out-of-range error pulse and a clear sweep that initialises the unreset storage array.
module host_mem_ctrl #(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 4,
    parameter int unsigned       DEPTH   = 16,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                  host_clk_i,
    input  logic                  reset_i,
    input  logic                  host_sel_i,
    input  logic                  host_wr_i,
    input  logic [ADDR_W-1:0]     host_addr_i,
    input  logic [DATA_W-1:0]     host_wdata_i,
    input  logic [DATA_W/8-1:0]   host_be_i,
    input  logic                  host_clr_i,
    output logic                  host_ready_o,
    output logic                  host_rvalid_o,
    output logic [DATA_W-1:0]     host_rdata_o,
    output logic                  host_err_o
);

    localparam int unsigned       BE_W    = DATA_W / 8;
    localparam int unsigned       CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    assign in_range     = ({1'b0, host_addr_i} < DEPTH_L);
    assign rd_word      = in_range ? mem[host_addr_i] : '0;
    assign host_ready_o = (state == IDLE);

    // Storage has no reset; it is initialised only by the clear sweep.
    always_ff @(posedge host_clk_i) begin
        if (!reset_i) begin
            if (state == CLEAR) begin
                mem[cnt] <= CLR_VAL;
            end else if (host_sel_i && host_wr_i && in_range) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (host_be_i[b]) begin
                        mem[host_addr_i][b*8 +: 8] <= host_wdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge host_clk_i) begin
        if (reset_i) begin
            state         <= CLEAR;
            cnt           <= '0;
            host_rvalid_o <= 1'b0;
            host_rdata_o  <= '0;
            host_err_o    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    host_rvalid_o <= 1'b0;
                    host_rdata_o  <= '0;
                    host_err_o    <= 1'b0;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    // A transaction accepted alongside a clear request still responds next cycle.
                    host_rvalid_o <= host_sel_i && !host_wr_i;
                    host_rdata_o  <= (host_sel_i && !host_wr_i) ? rd_word : '0;
                    host_err_o    <= host_sel_i && !in_range;
                    if (host_clr_i) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_mem_ctrl.sv
// Scoreboard bench: an 8-bit/16-entry instance and a 32-bit/12-entry instance driven in
// parallel; expected responses are queued at issue and popped by per-instance monitors.
module tb_host_mem_ctrl;

    typedef struct packed {
        logic        rv;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A: DATA_W=8, DEPTH=16, CLR_VAL=A5
    logic       a_rst, a_sel, a_wr, a_clr;
    logic [3:0] a_addr;
    logic [7:0] a_wdata;
    logic [0:0] a_be;
    logic       a_ready, a_rvalid, a_err;
    logic [7:0] a_rdata;

    // Instance B: DATA_W=32, DEPTH=12, CLR_VAL=0
    logic        b_rst, b_sel, b_wr, b_clr;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic        b_ready, b_rvalid, b_err;
    logic [31:0] b_rdata;

    host_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .CLR_VAL(8'hA5)) u_a (
        .host_clk_i(clk), .reset_i(a_rst), .host_sel_i(a_sel), .host_wr_i(a_wr),
        .host_addr_i(a_addr), .host_wdata_i(a_wdata), .host_be_i(a_be), .host_clr_i(a_clr),
        .host_ready_o(a_ready), .host_rvalid_o(a_rvalid), .host_rdata_o(a_rdata), .host_err_o(a_err)
    );

    host_mem_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .CLR_VAL(32'h0)) u_b (
        .host_clk_i(clk), .reset_i(b_rst), .host_sel_i(b_sel), .host_wr_i(b_wr),
        .host_addr_i(b_addr), .host_wdata_i(b_wdata), .host_be_i(b_be), .host_clr_i(b_clr),
        .host_ready_o(b_ready), .host_rvalid_o(b_rvalid), .host_rdata_o(b_rdata), .host_err_o(b_err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t mk(input logic rv, input logic err, input logic [31:0] data);
        exp_t e;
        e.rv   = rv;
        e.err  = err;
        e.data = data;
        return e;
    endfunction

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (!a_rvalid) chk("a_rdata_when_idle", 32'(a_rdata), 32'h0);
        if (a_rvalid || a_err) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_output", {30'h0, a_rvalid, a_err}, 32'h0);
            end else begin
                e = qa.pop_front();
                chk("a_rvalid", 32'(a_rvalid), 32'(e.rv));
                chk("a_err", 32'(a_err), 32'(e.err));
                chk("a_rdata", 32'(a_rdata), e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!b_rvalid) chk("b_rdata_when_idle", b_rdata, 32'h0);
        if (b_rvalid || b_err) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_output", {30'h0, b_rvalid, b_err}, 32'h0);
            end else begin
                e = qb.pop_front();
                chk("b_rvalid", 32'(b_rvalid), 32'(e.rv));
                chk("b_err", 32'(b_err), 32'(e.err));
                chk("b_rdata", b_rdata, e.data);
            end
        end
    end

    // Instance A stimulus
    task automatic a_op(input logic s, input logic w, input logic [3:0] ad,
                        input logic [7:0] d, input logic c);
        a_sel = s; a_wr = w; a_addr = ad; a_wdata = d; a_be = 1'b1; a_clr = c;
        @(posedge clk); #1;
        a_sel = 1'b0; a_clr = 1'b0;
    endtask

    task automatic a_rd(input logic [3:0] ad, input logic [7:0] exp);
        qa.push_back(mk(1'b1, 1'b0, 32'(exp)));
        a_op(1'b1, 1'b0, ad, 8'h00, 1'b0);
    endtask

    // Counts edges until ready; optionally drives junk accesses to address 0 meanwhile.
    task automatic a_wait_ready(input logic junk, output int n);
        n = 0;
        while (!a_ready && n < 100) begin
            a_sel = junk; a_wr = n[0]; a_addr = 4'd0; a_wdata = 8'hFF; a_be = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        a_sel = 1'b0;
    endtask

    task automatic seq_a();
        int n;
        a_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("a_reset_ready", 32'(a_ready), 32'h0);
        chk("a_reset_rvalid", 32'(a_rvalid), 32'h0);
        chk("a_reset_err", 32'(a_err), 32'h0);
        a_rst = 1'b0;
        a_wait_ready(1'b0, n);
        chk("a_init_sweep_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) a_rd(4'(i), 8'hA5);

        // Back-to-back write then read of the same entry
        a_op(1'b1, 1'b1, 4'd7, 8'h5C, 1'b0);
        a_rd(4'd7, 8'h5C);
        a_op(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

        for (int i = 0; i < 16; i++) a_op(1'b1, 1'b1, 4'(i), 8'(8'h10 + i), 1'b0);
        qa.push_back(mk(1'b1, 1'b0, 32'h12));
        a_op(1'b1, 1'b0, 4'd2, 8'h00, 1'b1);
        chk("a_clr_ready_low", 32'(a_ready), 32'h0);
        a_wait_ready(1'b1, n);
        chk("a_clr_sweep_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) a_rd(4'(i), 8'hA5);

        // Reset partway through a sweep
        for (int i = 0; i < 4; i++) a_op(1'b1, 1'b1, 4'(i), 8'h3C, 1'b0);
        a_op(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        a_wait_ready(1'b0, n);
        chk("a_restart_sweep_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) a_rd(4'(i), 8'hA5);
        a_op(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

    // Instance B stimulus
    task automatic b_op(input logic s, input logic w, input logic [3:0] ad,
                        input logic [31:0] d, input logic [3:0] be);
        b_sel = s; b_wr = w; b_addr = ad; b_wdata = d; b_be = be; b_clr = 1'b0;
        @(posedge clk); #1;
        b_sel = 1'b0;
    endtask

    task automatic b_rd(input logic [3:0] ad, input logic [31:0] exp, input logic err);
        qb.push_back(mk(1'b1, err, exp));
        b_op(1'b1, 1'b0, ad, 32'h0, 4'h0);
    endtask

    task automatic seq_b();
        int n;
        logic [31:0] model [12];
        b_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("b_reset_ready", 32'(b_ready), 32'h0);
        chk("b_reset_rdata", b_rdata, 32'h0);
        b_rst = 1'b0;
        n = 0;
        while (!b_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_init_sweep_cycles", 32'(n), 32'd12);
        for (int i = 0; i < 12; i++) model[i] = 32'h0;

        b_op(1'b1, 1'b1, 4'd3, 32'h11223344, 4'hF);
        b_op(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
        b_rd(4'd3, 32'h11BB33DD, 1'b0);
        model[3] = 32'h11BB33DD;

        b_op(1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h0);
        b_rd(4'd5, 32'h0, 1'b0);

        qb.push_back(mk(1'b0, 1'b1, 32'h0));
        b_op(1'b1, 1'b1, 4'd13, 32'h000000FF, 4'h1);
        b_rd(4'd13, 32'h0, 1'b1);
        b_rd(4'd12, 32'h0, 1'b1);
        b_rd(4'd15, 32'h0, 1'b1);
        for (int i = 0; i < 12; i++) b_rd(4'(i), model[i], 1'b0);
        b_op(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    endtask

    initial begin
        a_rst = 1'b1; a_sel = 1'b0; a_wr = 1'b0; a_clr = 1'b0;
        a_addr = '0; a_wdata = '0; a_be = '0;
        b_rst = 1'b1; b_sel = 1'b0; b_wr = 1'b0; b_clr = 1'b0;
        b_addr = '0; b_wdata = '0; b_be = '0;
        fork
            seq_a();
            seq_b();
        join
        repeat (3) @(posedge clk);
        #1;
        chk("a_pending_responses", 32'(qa.size()), 32'h0);
        chk("b_pending_responses", 32'(qb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/host_mem_ctrl.md
# host_mem_ctrl

Parametrised single-port host-accessible register memory with byte-enabled writes, a registered read-data path with valid strobe, out-of-range error reporting and a hardware clear sequencer. It sits behind the host interface as the generalised successor of the fixed 16x8 host memory. Software and bench access it through one select/write strobe pair. Contents are initialised by a sweep after reset or on request, with no reset on the storage array.

## Interface
- DATA_W, 8, data width in bits; must be a multiple of 8
- ADDR_W, 4, host address width
- DEPTH, 16, number of implemented entries; 1 <= DEPTH <= 2**ADDR_W
- CLR_VAL, 0, DATA_W-bit value written to every entry by the clear sweep
- host_clk_i  input  1  single clock; all logic on its rising edge
- reset_i  input  1  reset, synchronous, active-high
- host_sel_i  input  1  transaction request
- host_wr_i  input  1  1 = write, 0 = read; sampled with host_sel_i
- host_addr_i  input  ADDR_W  entry address
- host_wdata_i  input  DATA_W  write data
- host_be_i  input  DATA_W/8  byte enables for writes; ignored on reads
- host_clr_i  input  1  single-cycle request to start a clear sweep
- host_ready_o  output  1  block idle and able to accept a transaction
- host_rvalid_o  output  1  host_rdata_o valid this cycle (one-cycle pulse per read)
- host_rdata_o  output  DATA_W  registered read data
- host_err_o  output  1  one-cycle pulse: previous accepted access was out of range

## Operation
- States: CLEAR and IDLE. host_ready_o = (state == IDLE), combinational from state.
- Reset: any edge with reset_i high forces state=CLEAR, clear counter=0, host_rvalid_o=0, host_rdata_o=0, host_err_o=0. Storage array is not reset.
- CLEAR: each edge with reset_i low writes CLR_VAL to entry[counter] and increments counter. After the write of entry DEPTH-1, state moves to IDLE. A sweep takes exactly DEPTH cycles. host_sel_i and host_clr_i are ignored in CLEAR. Reset during CLEAR restarts the sweep at entry 0.
- IDLE: a transaction is accepted when host_sel_i && host_ready_o.
- Accepted write, addr < DEPTH: for each byte b with host_be_i[b]=1, entry[addr] byte b <= host_wdata_i byte b. Other bytes are unchanged. be=0 is a legal no-op.
- Accepted read, addr < DEPTH: next cycle host_rvalid_o=1 and host_rdata_o=entry[addr].
- addr >= DEPTH (only possible when DEPTH < 2**ADDR_W): write is dropped. A read still pulses host_rvalid_o with host_rdata_o=0. host_err_o pulses in both cases.
- host_rdata_o is 0 in every cycle host_rvalid_o is 0.
- host_clr_i in IDLE moves state to CLEAR on the next edge with counter=0. If host_sel_i is high in the same cycle, that transaction is accepted and completes normally first. Its read response appears in the first CLEAR cycle.

## Timing
- Reset values: host_ready_o=0, host_rvalid_o=0, host_rdata_o=0, host_err_o=0.
- Edge E0 is the last edge with reset_i high. host_ready_o rises after edge E0+DEPTH, i.e. DEPTH cycles after reset release.
- Write latency: write accepted at edge N is visible to a read accepted at edge N+1 (back-to-back RAW returns the new data).
- Read latency: 1 cycle. Read accepted at edge N gives host_rvalid_o/host_rdata_o high/valid during cycle N..N+1. Back-to-back reads give back-to-back valid pulses.
- host_err_o is aligned with the cycle in which host_rvalid_o would appear for the same access, 1 cycle after acceptance.
- Throughput: one transaction per cycle in IDLE, with no stalls.

## Test plan
- Reset held 3 cycles, then released, DEPTH=16, CLR_VAL=8'hA5 -> host_ready_o low for exactly 16 cycles then high. Reads of addresses 0..15 each return 8'hA5 with host_rvalid_o one cycle after sel.
- DATA_W=32 write addr 3 data 32'h11223344 be=4'hF, then write addr 3 data 32'hAABBCCDD be=4'b0101, then read addr 3 -> host_rdata_o=32'h11BB33DD.
- Write addr 7 = 8'h5C at edge N, read addr 7 at edge N+1 -> host_rdata_o=8'h5C, host_rvalid_o=1 in cycle N+2.
- DEPTH=12, ADDR_W=4: write addr 13 = 8'hFF, then read addr 13 -> host_err_o pulses after each access. The read returns rvalid=1, rdata=0. Reads of 0..11 are unchanged.
- Fill entries with distinct values, pulse host_clr_i together with a read of addr 2 -> old addr-2 value returned. ready is low 16 cycles, and all entries then read CLR_VAL. sel during CLEAR causes no write and no rvalid.
- Assert reset_i at the 5th cycle of a clear sweep -> sweep restarts at entry 0 and ready returns DEPTH cycles after reset release. rvalid/err are 0 throughout.
